// File: rtl/memory_port_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter.
package memory_port_arbiter_pkg;

    localparam logic STATE__IDLE      = 1'b0;
    localparam logic STATE__READ_WAIT = 1'b1;

    localparam logic REQ__IFETCH = 1'b0;
    localparam logic REQ__DATA   = 1'b1;

    typedef enum logic {
        ST_IDLE      = STATE__IDLE,
        ST_READ_WAIT = STATE__READ_WAIT
    } state_e;

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Bundle of both requester channels plus the shared memory port.
// Handshake: a requester holds valid/we/addr/wr_data stable until it sees a one-cycle
// ready pulse; that pulse completes the transaction (rd_data is valid only alongside it).
interface memory_port_arbiter_if #(
    parameter int ADDR_WIDTH = 61,
    parameter int DATA_WIDTH = 64
);
    logic                  req0__valid;
    logic                  req0__ready;
    logic                  req0__we;
    logic [ADDR_WIDTH-1:0] req0__addr;
    logic [DATA_WIDTH-1:0] req0__wr_data;
    logic [DATA_WIDTH-1:0] req0__rd_data;

    logic                  req1__valid;
    logic                  req1__ready;
    logic                  req1__we;
    logic [ADDR_WIDTH-1:0] req1__addr;
    logic [DATA_WIDTH-1:0] req1__wr_data;
    logic [DATA_WIDTH-1:0] req1__rd_data;

    logic [ADDR_WIDTH-1:0] mem__addr;
    logic [DATA_WIDTH-1:0] mem__wr_data;
    logic [DATA_WIDTH-1:0] mem__rd_data;
    logic                  mem__en;
    logic                  mem__we;

    modport slave (
        input  req0__valid, req0__we, req0__addr, req0__wr_data,
        output req0__ready, req0__rd_data,
        input  req1__valid, req1__we, req1__addr, req1__wr_data,
        output req1__ready, req1__rd_data,
        output mem__addr, mem__wr_data, mem__en, mem__we,
        input  mem__rd_data
    );

    modport master (
        output req0__valid, req0__we, req0__addr, req0__wr_data,
        input  req0__ready, req0__rd_data,
        output req1__valid, req1__we, req1__addr, req1__wr_data,
        input  req1__ready, req1__rd_data,
        input  mem__addr, mem__wr_data, mem__en, mem__we,
        output mem__rd_data
    );

endinterface

// File: rtl/memory_port_arbiter_rr_select2.sv
// Combinational two-way round-robin pick: under contention the requester that was
// not granted last time wins.
module rr_select2
    import memory_port_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant,
    output logic       id
);

    always_comb begin
        grant = |valid;
        id    = REQ__IFETCH;
        case (valid)
            2'b10:   id = REQ__DATA;
            2'b11:   id = ~last;
            default: id = REQ__IFETCH;
        endcase
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Serialises instruction-side and data-side requests onto one memory port.
// Optional perf counters are built when MEMORY_PORT_ARBITER_PERF_EN is defined.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 61,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    memory_port_arbiter_if.slave         bus,
    output logic                         state_dbg
`ifdef MEMORY_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]                  perf__grant0,
    output logic [31:0]                  perf__grant1,
    output logic [31:0]                  perf__conflict
`endif
);

    state_e          state, state_nxt;
    logic            owner, owner_nxt;
    logic            last, last_nxt;
    logic [2:0]      cnt, cnt_nxt;

    logic            grant;
    logic            gid;
    logic            sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wr_data;

    logic            mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [1:0]      ready;
    logic [DATA_WIDTH-1:0] rd_data0, rd_data1;

    rr_select2 u_sel (
        .valid ({bus.req1__valid, bus.req0__valid}),
        .last  (last),
        .grant (grant),
        .id    (gid)
    );

    assign sel_we      = gid ? bus.req1__we      : bus.req0__we;
    assign sel_addr    = gid ? bus.req1__addr    : bus.req0__addr;
    assign sel_wr_data = gid ? bus.req1__wr_data : bus.req0__wr_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= REQ__IFETCH;
            last  <= REQ__DATA;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Everything is gated by rst so outputs read as zero while reset is held.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        cnt_nxt     = cnt;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        ready       = 2'b00;
        rd_data0    = '0;
        rd_data1    = '0;
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        last_nxt = gid;
                        mem_en   = 1'b1;
                        mem_we   = sel_we;
                        mem_addr = sel_addr;
                        if (sel_we) begin
                            mem_wr_data = sel_wr_data;
                            ready[gid]  = 1'b1;
                        end else begin
                            owner_nxt = gid;
                            cnt_nxt   = 3'(READ_LATENCY - 1);
                            state_nxt = ST_READ_WAIT;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt_nxt = cnt - 3'd1;
                    end else begin
                        ready[owner] = 1'b1;
                        if (owner == REQ__DATA) rd_data1 = bus.mem__rd_data;
                        else                    rd_data0 = bus.mem__rd_data;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.mem__en       = mem_en;
    assign bus.mem__we       = mem_we;
    assign bus.mem__addr     = mem_addr;
    assign bus.mem__wr_data  = mem_wr_data;
    assign bus.req0__ready   = ready[0];
    assign bus.req1__ready   = ready[1];
    assign bus.req0__rd_data = rd_data0;
    assign bus.req1__rd_data = rd_data1;
    assign state_dbg         = state;

`ifdef MEMORY_PORT_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf__grant0   <= 32'd0;
            perf__grant1   <= 32'd0;
            perf__conflict <= 32'd0;
        end else if (state == ST_IDLE) begin
            if (grant && gid == REQ__IFETCH) perf__grant0 <= perf__grant0 + 32'd1;
            if (grant && gid == REQ__DATA)   perf__grant1 <= perf__grant1 + 32'd1;
            if (bus.req0__valid && bus.req1__valid) perf__conflict <= perf__conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios on a latency-1 and a latency-3
// instance, then randomized traffic against a transaction-level reference model.
module tb_memory_port_arbiter;

    localparam int AW    = 61;
    localparam int DW    = 64;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic st_a, st_b;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef MEMORY_PORT_ARBITER_PERF_EN
    logic [31:0] pa_g0, pa_g1, pa_cf, pb_g0, pb_g1, pb_cf;
`endif

    memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa), .state_dbg(st_a)
`ifdef MEMORY_PORT_ARBITER_PERF_EN
        , .perf__grant0(pa_g0), .perf__grant1(pa_g1), .perf__conflict(pa_cf)
`endif
    );

    memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb), .state_dbg(st_b)
`ifdef MEMORY_PORT_ARBITER_PERF_EN
        , .perf__grant0(pb_g0), .perf__grant1(pb_g1), .perf__conflict(pb_cf)
`endif
    );

    task automatic idle_inputs();
        ifa.req0__valid = 0; ifa.req0__we = 0; ifa.req0__addr = '0; ifa.req0__wr_data = '0;
        ifa.req1__valid = 0; ifa.req1__we = 0; ifa.req1__addr = '0; ifa.req1__wr_data = '0;
        ifa.mem__rd_data = '0;
        ifb.req0__valid = 0; ifb.req0__we = 0; ifb.req0__addr = '0; ifb.req0__wr_data = '0;
        ifb.req1__valid = 0; ifb.req1__we = 0; ifb.req1__addr = '0; ifb.req1__wr_data = '0;
        ifb.mem__rd_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset held with traffic on the inputs: every output must read zero.
    task automatic test_reset();
        rst_a = 0; rst_b = 0;
        ifa.req0__valid = 1; ifa.req0__we = 1; ifa.req0__addr = 61'h1f; ifa.req0__wr_data = 64'h55;
        ifa.req1__valid = 1; ifa.req1__addr = 61'h2f; ifa.mem__rd_data = 64'habcd;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_vec++;
        if ({ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready});
        end
        n_vec++;
        if (ifa.mem__addr !== '0 || ifa.mem__wr_data !== '0) begin
            n_err++;
            $display("FAIL reset_bus: addr %h wr %h want 0", ifa.mem__addr, ifa.mem__wr_data);
        end
        n_vec++;
        if (ifa.req0__rd_data !== '0 || ifa.req1__rd_data !== '0 || st_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rd: rd0 %h rd1 %h state %b want 0",
                     ifa.req0__rd_data, ifa.req1__rd_data, st_a);
        end
`ifdef MEMORY_PORT_ARBITER_PERF_EN
        n_vec++;
        if ({pa_g0, pa_g1, pa_cf} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_perf: got %0d %0d %0d want 0 0 0", pa_g0, pa_g1, pa_cf);
        end
`endif
        next_cycle();
        idle_inputs();
        rst_a = 1; rst_b = 1;
    endtask

    task automatic test_read_latency();
        ifa.req0__valid = 1; ifa.req0__we = 0; ifa.req0__addr = 61'h10;
        @(negedge clk);
        n_vec++;
        if ({ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready} !== 4'b1000
            || ifa.mem__addr !== 61'h10) begin
            n_err++;
            $display("FAIL rl_issue: ctl %b addr %h want 1000 10",
                     {ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready}, ifa.mem__addr);
        end
        next_cycle();
        ifa.mem__rd_data = 64'hdeadbeef;
        @(negedge clk);
        n_vec++;
        if ({ifa.mem__en, ifa.req0__ready, ifa.req1__ready} !== 3'b010
            || ifa.req0__rd_data !== 64'hdeadbeef || ifa.req1__rd_data !== '0) begin
            n_err++;
            $display("FAIL rl_return: ctl %b rd0 %h rd1 %h want 010 deadbeef 0",
                     {ifa.mem__en, ifa.req0__ready, ifa.req1__ready},
                     ifa.req0__rd_data, ifa.req1__rd_data);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 3; i++) begin
            a = AW'(4 + i);
            d = 64'h1000 + DW'(i);
            ifa.req1__valid = 1; ifa.req1__we = 1; ifa.req1__addr = a; ifa.req1__wr_data = d;
            @(negedge clk);
            n_vec++;
            if ({ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready} !== 4'b1101
                || ifa.mem__addr !== a || ifa.mem__wr_data !== d) begin
                n_err++;
                $display("FAIL b2b_wr%0d: ctl %b addr %h wr %h want 1101 %h %h", i,
                         {ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready},
                         ifa.mem__addr, ifa.mem__wr_data, a, d);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (ifa.mem__en !== 1'b0 || ifa.mem__addr !== '0 || ifa.mem__wr_data !== '0) begin
            n_err++;
            $display("FAIL idle_bus: en %b addr %h wr %h want 0", ifa.mem__en, ifa.mem__addr,
                     ifa.mem__wr_data);
        end
        next_cycle();
    endtask

    // After reset both read at once: req0 first, req1 two cycles later, req0 again next.
    task automatic test_contention();
        rst_a = 0;
        next_cycle();
        rst_a = 1;
        ifa.req0__valid = 1; ifa.req0__we = 0; ifa.req0__addr = 61'h20;
        ifa.req1__valid = 1; ifa.req1__we = 0; ifa.req1__addr = 61'h30;
        @(negedge clk);
        n_vec++;
        if (ifa.mem__en !== 1'b1 || ifa.mem__addr !== 61'h20) begin
            n_err++;
            $display("FAIL cont_first: en %b addr %h want 1 20", ifa.mem__en, ifa.mem__addr);
        end
        next_cycle();
        ifa.mem__rd_data = 64'ha0;
        @(negedge clk);
        n_vec++;
        if ({ifa.mem__en, ifa.req0__ready, ifa.req1__ready} !== 3'b010 || ifa.req0__rd_data !== 64'ha0) begin
            n_err++;
            $display("FAIL cont_ret0: ctl %b rd0 %h want 010 a0",
                     {ifa.mem__en, ifa.req0__ready, ifa.req1__ready}, ifa.req0__rd_data);
        end
        next_cycle();
        ifa.req0__valid = 0;
        ifa.mem__rd_data = 64'h77;
        @(negedge clk);
        n_vec++;
        if (ifa.mem__en !== 1'b1 || ifa.mem__addr !== 61'h30) begin
            n_err++;
            $display("FAIL cont_second: en %b addr %h want 1 30", ifa.mem__en, ifa.mem__addr);
        end
        next_cycle();
        ifa.mem__rd_data = 64'hb0;
        @(negedge clk);
        n_vec++;
        if ({ifa.req0__ready, ifa.req1__ready} !== 2'b01 || ifa.req1__rd_data !== 64'hb0
            || ifa.req0__rd_data !== '0) begin
            n_err++;
            $display("FAIL cont_ret1: rdy %b rd1 %h rd0 %h want 01 b0 0",
                     {ifa.req0__ready, ifa.req1__ready}, ifa.req1__rd_data, ifa.req0__rd_data);
        end
        next_cycle();
        ifa.req0__valid = 1; ifa.req0__addr = 61'h40;
        ifa.req1__addr = 61'h50;
        @(negedge clk);
        n_vec++;
        if (ifa.mem__en !== 1'b1 || ifa.mem__addr !== 61'h40) begin
            n_err++;
            $display("FAIL cont_again: en %b addr %h want 1 40", ifa.mem__en, ifa.mem__addr);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_long_latency();
        ifb.req1__valid = 1; ifb.req1__we = 0; ifb.req1__addr = 61'h77;
        @(negedge clk);
        n_vec++;
        if (ifb.mem__en !== 1'b1 || ifb.mem__we !== 1'b0 || ifb.mem__addr !== 61'h77) begin
            n_err++;
            $display("FAIL ll_issue: en %b we %b addr %h want 1 0 77", ifb.mem__en, ifb.mem__we,
                     ifb.mem__addr);
        end
        for (int k = 1; k < LAT_B; k++) begin
            next_cycle();
            ifb.mem__rd_data = 64'hbad0 + DW'(k);
            @(negedge clk);
            n_vec++;
            if ({ifb.mem__en, ifb.req0__ready, ifb.req1__ready} !== 3'b000) begin
                n_err++;
                $display("FAIL ll_wait%0d: ctl %b want 000", k,
                         {ifb.mem__en, ifb.req0__ready, ifb.req1__ready});
            end
        end
        next_cycle();
        ifb.mem__rd_data = 64'h1234;
        @(negedge clk);
        n_vec++;
        if ({ifb.mem__en, ifb.req0__ready, ifb.req1__ready} !== 3'b001 || ifb.req1__rd_data !== 64'h1234) begin
            n_err++;
            $display("FAIL ll_return: ctl %b rd1 %h want 001 1234",
                     {ifb.mem__en, ifb.req0__ready, ifb.req1__ready}, ifb.req1__rd_data);
        end
`ifdef MEMORY_PORT_ARBITER_PERF_EN
        n_vec++;
        if ({pb_g0, pb_g1, pb_cf} !== {32'd0, 32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL ll_perf: got %0d %0d %0d want 0 1 0", pb_g0, pb_g1, pb_cf);
        end
`endif
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        ifb.req0__valid = 1; ifb.req0__we = 0; ifb.req0__addr = 61'h88;
        next_cycle();
        rst_b = 0;
        @(negedge clk);
        n_vec++;
        if ({ifb.mem__en, ifb.req0__ready, ifb.req1__ready} !== 3'b000 || ifb.req0__rd_data !== '0) begin
            n_err++;
            $display("FAIL rmr_held: ctl %b rd0 %h want 000 0",
                     {ifb.mem__en, ifb.req0__ready, ifb.req1__ready}, ifb.req0__rd_data);
        end
        next_cycle();
        rst_b = 1;
        ifb.req1__valid = 1; ifb.req1__we = 0; ifb.req1__addr = 61'h99;
        @(negedge clk);
        n_vec++;
        if (st_b !== 1'b0 || ifb.mem__en !== 1'b1 || ifb.mem__addr !== 61'h88) begin
            n_err++;
            $display("FAIL rmr_regrant: state %b en %b addr %h want 0 1 88", st_b, ifb.mem__en,
                     ifb.mem__addr);
        end
        // The aborted read would have completed here; its late data must be ignored.
        next_cycle();
        ifb.mem__rd_data = 64'hdead;
        @(negedge clk);
        n_vec++;
        if ({ifb.mem__en, ifb.req0__ready, ifb.req1__ready} !== 3'b000) begin
            n_err++;
            $display("FAIL rmr_late: ctl %b want 000", {ifb.mem__en, ifb.req0__ready, ifb.req1__ready});
        end
        idle_inputs();
        rst_b = 0;
        next_cycle();
        rst_b = 1;
    endtask

    // Randomized traffic checked against a transaction-level view of the port.
    task automatic test_random(input int ncyc);
        logic          act[2];
        logic          op_we[2];
        logic [AW-1:0] op_addr[2];
        logic [DW-1:0] op_data[2];
        logic [DW-1:0] ref_mem[8];
        logic [DW-1:0] phys_mem[8];
        logic          exp_rdy[2];
        logic [DW-1:0] exp_rd[2];
        logic [DW-1:0] rd_exp, ret_data, exp_wd;
        logic [AW-1:0] exp_addr;
        logic          exp_en, exp_we, check_wd, last_m, owner_m, gid_m;
        int            free_at, rd_done, ret_cyc;
        int            grants[2];
        int            conflicts;

        rst_a = 0;
        next_cycle();
        rst_a = 1;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i]  = {$urandom, $urandom};
            phys_mem[i] = ref_mem[i];
        end
        act[0] = 0; act[1] = 0;
        free_at = 0; rd_done = -1; ret_cyc = -1; ret_data = '0;
        last_m = 1; owner_m = 0; rd_exp = '0;
        grants[0] = 0; grants[1] = 0; conflicts = 0;

        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!act[r] && $urandom_range(0, 3) != 0) begin
                    act[r]     = 1;
                    op_we[r]   = 1'($urandom_range(0, 1));
                    op_addr[r] = (AW'($urandom) << 3) | AW'($urandom_range(0, 7));
                    op_data[r] = {$urandom, $urandom};
                end
            end
            ifa.req0__valid = act[0]; ifa.req0__we = op_we[0];
            ifa.req0__addr = op_addr[0]; ifa.req0__wr_data = op_data[0];
            ifa.req1__valid = act[1]; ifa.req1__we = op_we[1];
            ifa.req1__addr = op_addr[1]; ifa.req1__wr_data = op_data[1];
            ifa.mem__rd_data = (ret_cyc == cyc) ? ret_data : {$urandom, $urandom};
            @(negedge clk);

            exp_en = 0; exp_we = 0; exp_addr = '0; exp_wd = '0; check_wd = 1;
            exp_rdy[0] = 0; exp_rdy[1] = 0; exp_rd[0] = '0; exp_rd[1] = '0;
            if (cyc < free_at) begin
                if (cyc == rd_done) begin
                    exp_rdy[owner_m] = 1;
                    exp_rd[owner_m]  = rd_exp;
                end
            end else if (act[0] || act[1]) begin
                if (act[0] && act[1]) begin
                    gid_m = ~last_m;
                    conflicts++;
                end else begin
                    gid_m = act[1];
                end
                last_m = gid_m;
                grants[gid_m]++;
                exp_en = 1; exp_we = op_we[gid_m]; exp_addr = op_addr[gid_m];
                if (op_we[gid_m]) begin
                    exp_wd = op_data[gid_m];
                    exp_rdy[gid_m] = 1;
                    ref_mem[op_addr[gid_m][2:0]] = op_data[gid_m];
                end else begin
                    check_wd = 0;
                    rd_exp   = ref_mem[op_addr[gid_m][2:0]];
                    owner_m  = gid_m;
                    rd_done  = cyc + LAT_A;
                    free_at  = cyc + LAT_A + 1;
                end
            end

            n_vec++;
            if ({ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready}
                !== {exp_en, exp_we, exp_rdy[0], exp_rdy[1]} || ifa.mem__addr !== exp_addr) begin
                n_err++;
                $display("FAIL rnd_ctl c%0d: ctl %b addr %h want %b %h", cyc,
                         {ifa.mem__en, ifa.mem__we, ifa.req0__ready, ifa.req1__ready}, ifa.mem__addr,
                         {exp_en, exp_we, exp_rdy[0], exp_rdy[1]}, exp_addr);
            end
            if (check_wd) begin
                n_vec++;
                if (ifa.mem__wr_data !== exp_wd) begin
                    n_err++;
                    $display("FAIL rnd_wdata c%0d: got %h want %h", cyc, ifa.mem__wr_data, exp_wd);
                end
            end
            n_vec++;
            if (ifa.req0__rd_data !== exp_rd[0] || ifa.req1__rd_data !== exp_rd[1]) begin
                n_err++;
                $display("FAIL rnd_rdata c%0d: got %h %h want %h %h", cyc, ifa.req0__rd_data,
                         ifa.req1__rd_data, exp_rd[0], exp_rd[1]);
            end

            // The memory itself reacts to whatever the DUT actually drove.
            if (ifa.mem__en === 1'b1) begin
                if (ifa.mem__we === 1'b1) begin
                    phys_mem[ifa.mem__addr[2:0]] = ifa.mem__wr_data;
                end else begin
                    ret_cyc  = cyc + LAT_A;
                    ret_data = phys_mem[ifa.mem__addr[2:0]];
                end
            end
            for (int r = 0; r < 2; r++) if (exp_rdy[r]) act[r] = 0;
            next_cycle();
        end
        idle_inputs();
`ifdef MEMORY_PORT_ARBITER_PERF_EN
        @(negedge clk);
        n_vec++;
        if (pa_g0 !== 32'(grants[0]) || pa_g1 !== 32'(grants[1]) || pa_cf !== 32'(conflicts)) begin
            n_err++;
            $display("FAIL rnd_perf: got %0d %0d %0d want %0d %0d %0d", pa_g0, pa_g1, pa_cf,
                     grants[0], grants[1], conflicts);
        end
`endif
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        rst_a = 0; rst_b = 0;
        #1;
        test_reset();
        test_read_latency();
        test_back_to_back();
        test_contention();
        test_long_latency();
        test_reset_mid_read();
        test_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: requester 0 (instruction-side L1) and requester 1 (data-side L1).
- Each requester uses a valid/ready request channel.
- Transactions are serialized with round-robin fairness.
- Drives the core's top-level memory port (addr/wr_data/rd_data/en/we).

Parameters:
ADDR_WIDTH, 61, word-address width of requester and memory ports
DATA_WIDTH, 64, data width
READ_LATENCY, 1, cycles from en=1/we=0 until mem__rd_data is valid; legal range 1..7

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (0 = reset)
req0__valid  input  1  requester 0 transaction request
req0__ready  output  1  one-cycle pulse: requester 0 transaction complete
req0__we  input  1  requester 0 write enable
req0__addr  input  ADDR_WIDTH  requester 0 word address
req0__wr_data  input  DATA_WIDTH  requester 0 write data
req0__rd_data  output  DATA_WIDTH  requester 0 read data, valid while req0__ready=1
req1__valid, req1__ready, req1__we, req1__addr, req1__wr_data, req1__rd_data  (same as requester 0, for requester 1)
mem__addr  output  ADDR_WIDTH  memory address
mem__wr_data  output  DATA_WIDTH  memory write data
mem__rd_data  input  DATA_WIDTH  memory read data
mem__en  output  1  memory access strobe
mem__we  output  1  memory write strobe

Behaviour:
- FSM states: IDLE, READ_WAIT.
- Registers:
  - state
  - owner (1 bit): requester being served
  - last (1 bit): last granted requester
  - cnt (3 bits): read latency countdown
- Reset (rst=0 at posedge): state=IDLE, last=1 (requester 0 wins first contention), cnt=0.
- While rst=0: all outputs are forced to 0 combinationally (mem__en, mem__we, req*__ready, mem__addr, mem__wr_data). rd_data outputs are 0.
- IDLE, grant selection:
  - Exactly one valid: that requester is granted.
  - Both valid: the requester != last is granted.
  - Grant is combinational in the same cycle; last <= granted id.
- IDLE, granted write (we=1):
  - Same cycle: mem__en=1, mem__we=1, addr and wr_data from the granted requester.
  - reqX__ready=1 in that same cycle (zero-wait write).
  - State stays IDLE, so back-to-back writes are possible every cycle.
- IDLE, granted read (we=0):
  - Same cycle: mem__en=1, mem__we=0, mem__addr=granted addr.
  - owner <= id, cnt <= READ_LATENCY-1, state <= READ_WAIT.
- READ_WAIT:
  - mem__en=0.
  - If cnt!=0: cnt decrements.
  - If cnt==0: req[owner]__ready=1 and req[owner]__rd_data=mem__rd_data, state <= IDLE.
  - No new grant is issued in this cycle. Read-to-next-access gap is READ_LATENCY+1 cycles from issue.
- Non-owner requesters see ready=0. Requesters hold valid/we/addr/wr_data stable until ready. Valid deasserted before ready is illegal (unchecked).
- mem__addr/mem__wr_data in IDLE with no grant: 0.
- rd_data outputs of the non-ready requester: 0.
- Reset during READ_WAIT:
  - Transaction is aborted; no ready pulse is issued.
  - The late memory data is ignored.
- Simultaneous valid from both sides while a read is pending: the next grant after return goes to the non-last requester.

Optional Feature:
- Macro: MEMORY_PORT_ARBITER_PERF_EN.
- When defined, adds outputs perf__grant0 and perf__grant1 (32 bits each) and perf__conflict (32 bits).
  - perf__grant0 / perf__grant1 increment on each grant to the respective requester.
  - perf__conflict increments on each IDLE cycle where both valids are high.
  - All counters wrap at 2^32 and reset to 0.
- When undefined: the ports and logic are absent; the port list is otherwise identical.

Decomposition:
- Package memory_port_arbiter_pkg holds:
  - state encoding localparams STATE__IDLE=1'b0, STATE__READ_WAIT=1'b1
  - requester ids REQ__IFETCH=1'b0, REQ__DATA=1'b1
- Sub-module rr_select2 (combinational 2-way round-robin pick from valid[1:0] and last) is natural and reused.
- Perf counters stay inline.

Test Plan:
- Read latency: READ_LATENCY=1, req0 read addr 0x10, memory returns 0xDEADBEEF → mem__en pulses once at cycle T; req0__ready=1 with rd_data=0xDEADBEEF at T+1.
- Back-to-back writes: req1 writes addr 0x4/0x5/0x6 on consecutive cycles → mem__en=mem__we=1 for three cycles; req1__ready high each cycle.
- Contention: both valid first cycle after reset, both reads → req0 served first, req1 issued at T+2; then both valid again → req0 served next (last was 1).
- Longer latency: READ_LATENCY=3, req1 read → ready at T+3; mem__en low at T+1..T+3.
- Reset mid-read: rst=0 during READ_WAIT → no ready pulse; after release, state=IDLE, req0 wins contention.
- Perf counters (macro defined): 5 req0 grants, 3 req1 grants, 2 conflict cycles → perf__grant0=5, perf__grant1=3, perf__conflict=2.
